metronome_beat_gen: RTL and testbench
=====================================

Name: metronome_beat_gen

Overview:
Reader side of the BPM phase accumulator. Samples the free-running ACC_W-bit accumulator value and its change strobe, and detects each accumulator wrap as one beat. Each beat produces a one-cycle tick, a beat-in-bar index with a bar-start accent, and a gated square-wave click for the buzzer/audio output stage.

Parameters:
ACC_W, 34, width of the accumulator input.
BEATS_PER_BAR, 4, beats per bar; legal range 1..16; beat 0 is accented.
CLICK_LEN, 2500000, click gate length in i_clk cycles (50 ms at 50 MHz); must be >= 1.
ACCENT_HALF, 28409, half-period in cycles of the accent tone (880 Hz at 50 MHz); must be >= 1.
NORMAL_HALF, 56818, half-period in cycles of the normal tone (440 Hz at 50 MHz); must be >= 1.

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  metronome run; low = silent, index held at 0
i_bpm_counter  in  ACC_W  phase accumulator value (mod 2^ACC_W)
i_bpm_changed  in  1  one-cycle strobe: tempo increment changed
o_beat_tick  out  1  one-cycle pulse per beat
o_beat_idx  out  4  index of the current beat, 0..BEATS_PER_BAR-1
o_accent  out  1  high while the current click is a bar-start (beat 0) click
o_click_gate  out  1  high for the click duration
o_click_wave  out  1  square-wave tone, gated by o_click_gate

Behaviour:
- Reset (async): r_prev=0, r_prev_valid=0, resync_pend=1, state=IDLE, all outputs 0, o_beat_idx=0.
- Sampling: r_prev <= i_bpm_counter every cycle; r_prev_valid <= 1 after the first post-reset cycle.
- Wrap detect: wrap = r_prev_valid & i_enable & (i_bpm_counter < r_prev), using an unsigned ACC_W-bit compare. Equal values (zero increment) never wrap.
- Latency: o_beat_tick is high exactly in the cycle after the first cycle in which i_bpm_counter presents the wrapped value. o_beat_idx and o_accent update on that same edge.
- Beat index on wrap:
  - If resync_pend=1 or i_bpm_changed=1 in the same cycle: idx=0 and resync_pend is cleared.
  - Otherwise: idx = (idx==BEATS_PER_BAR-1) ? 0 : idx+1.
  - o_accent = (new idx==0).
- i_bpm_changed without a wrap sets resync_pend=1. The next beat is forced to beat 0 and accented.
- FSM states:
  - IDLE: gate=0, wave=0. On wrap, go to CLICK, load len_cnt=CLICK_LEN-1, tone_cnt=half-1 (half = ACCENT_HALF if accent, else NORMAL_HALF), wave=1.
  - CLICK: gate=1. tone_cnt decrements; at 0, wave toggles and tone_cnt reloads half-1. len_cnt decrements; at 0, go to IDLE with gate=0, wave=0, o_accent=0.
  - A wrap during CLICK retriggers the click: reload len_cnt and tone_cnt, wave=1, half chosen by the new accent.
- i_enable low:
  - Immediately (next edge) go to IDLE, gate=0, wave=0, tick=0.
  - o_beat_idx=0 and resync_pend=1, so the first beat after re-enable is an accented beat 0.
  - r_prev keeps sampling while disabled.
- Counter widths: len_cnt is clog2(CLICK_LEN) bits; tone_cnt is clog2(max half) bits. No counter is ever loaded with a negative value.
- BEATS_PER_BAR=1: every beat is idx 0 and accented.
- Reset mid-click: outputs drop asynchronously; the next beat after release is an accented beat 0.

Test Plan:
1. ACC_W=8, CLICK_LEN=10, ACCENT_HALF=2, NORMAL_HALF=3; drive the counter 250,254,2 with enable=1 → o_beat_tick=1 one cycle after 2 is presented, o_beat_idx=0, o_accent=1, gate high for exactly 10 cycles, wave toggles every 2 cycles starting at 1.
2. Same parameters; four more wraps → idx sequence 1,2,3,0, o_accent high only on idx 0, wave half-period 3 on non-accent beats.
3. Pulse i_bpm_changed at idx=2, then wrap → next beat is idx 0 with accent. Changed and wrap in the same cycle → that beat is idx 0.
4. Second wrap 4 cycles into a click → gate stays high for 10 cycles from the second tick (14 total), tone reloaded.
5. Drop i_enable mid-click → gate/wave 0 on the next edge, wraps ignored while low. Re-enable, then wrap → idx 0, accent.
6. Hold the counter constant (zero increment), and separately assert async reset mid-click → no ticks; on reset, all outputs 0 without waiting for a clock edge, and the first beat after reset is idx 0, accent.

Source files
------------

// File: rtl/metronome_beat_gen.sv
// Beat generator: turns phase-accumulator wraps into beat ticks, a beat-in-bar
// index with bar-start accent, and a gated square-wave click.
module metronome_beat_gen #(
  parameter int unsigned ACC_W         = 34,
  parameter int unsigned BEATS_PER_BAR = 4,
  parameter int unsigned CLICK_LEN     = 2500000,
  parameter int unsigned ACCENT_HALF   = 28409,
  parameter int unsigned NORMAL_HALF   = 56818
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [ACC_W-1:0] i_bpm_counter,
  input  logic             i_bpm_changed,
  output logic             o_beat_tick,
  output logic [3:0]       o_beat_idx,
  output logic             o_accent,
  output logic             o_click_gate,
  output logic             o_click_wave
);

  localparam int unsigned MAX_HALF = (ACCENT_HALF > NORMAL_HALF) ? ACCENT_HALF : NORMAL_HALF;
  localparam int unsigned LEN_W    = (CLICK_LEN > 1) ? $clog2(CLICK_LEN) : 1;
  localparam int unsigned TONE_W   = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

  localparam logic [3:0]        LAST_IDX    = 4'(BEATS_PER_BAR - 1);
  localparam logic [LEN_W-1:0]  LEN_LOAD    = LEN_W'(CLICK_LEN - 1);
  localparam logic [TONE_W-1:0] ACCENT_LOAD = TONE_W'(ACCENT_HALF - 1);
  localparam logic [TONE_W-1:0] NORMAL_LOAD = TONE_W'(NORMAL_HALF - 1);

  typedef enum logic {IDLE, CLICK} state_t;

  state_t            state;
  logic [ACC_W-1:0]  prev;
  logic              prev_valid;
  logic              resync_pend;
  logic [LEN_W-1:0]  len_cnt;
  logic [TONE_W-1:0] tone_cnt;

  logic              wrap;
  logic [3:0]        beat_next;
  logic [TONE_W-1:0] start_load;
  logic [TONE_W-1:0] running_load;

  // A smaller sample than last cycle means the accumulator rolled over.
  assign wrap = prev_valid & i_enable & (i_bpm_counter < prev);

  always_comb begin
    beat_next = 4'd0;
    if (!(resync_pend | i_bpm_changed) && (o_beat_idx != LAST_IDX))
      beat_next = o_beat_idx + 4'd1;
  end

  assign start_load   = (beat_next == 4'd0) ? ACCENT_LOAD : NORMAL_LOAD;
  assign running_load = o_accent ? ACCENT_LOAD : NORMAL_LOAD;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      prev         <= '0;
      prev_valid   <= 1'b0;
      resync_pend  <= 1'b1;
      len_cnt      <= '0;
      tone_cnt     <= '0;
      o_beat_tick  <= 1'b0;
      o_beat_idx   <= 4'd0;
      o_accent     <= 1'b0;
      o_click_gate <= 1'b0;
      o_click_wave <= 1'b0;
    end else begin
      prev        <= i_bpm_counter;
      prev_valid  <= 1'b1;
      o_beat_tick <= wrap;

      if (!i_enable) begin
        state        <= IDLE;
        o_beat_idx   <= 4'd0;
        o_accent     <= 1'b0;
        o_click_gate <= 1'b0;
        o_click_wave <= 1'b0;
        resync_pend  <= 1'b1;
      end else if (wrap) begin
        // New beat starts (or restarts) a click with the tone of the new beat.
        state        <= CLICK;
        o_beat_idx   <= beat_next;
        o_accent     <= (beat_next == 4'd0);
        resync_pend  <= 1'b0;
        len_cnt      <= LEN_LOAD;
        tone_cnt     <= start_load;
        o_click_gate <= 1'b1;
        o_click_wave <= 1'b1;
      end else begin
        if (i_bpm_changed)
          resync_pend <= 1'b1;
        case (state)
          IDLE: begin
            o_click_gate <= 1'b0;
            o_click_wave <= 1'b0;
          end
          CLICK: begin
            if (len_cnt == '0) begin
              state        <= IDLE;
              o_click_gate <= 1'b0;
              o_click_wave <= 1'b0;
              o_accent     <= 1'b0;
            end else begin
              len_cnt <= len_cnt - LEN_W'(1);
              if (tone_cnt == '0) begin
                o_click_wave <= ~o_click_wave;
                tone_cnt     <= running_load;
              end else begin
                tone_cnt <= tone_cnt - TONE_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_metronome_beat_gen.sv
// Scoreboard bench for metronome_beat_gen: stimulus queues expected beats,
// a negedge monitor checks each tick; click shapes are checked inline.
module tb_metronome_beat_gen;

  localparam int unsigned ACC_W         = 8;
  localparam int unsigned BEATS_PER_BAR = 4;
  localparam int unsigned CLICK_LEN     = 10;
  localparam int unsigned ACCENT_HALF   = 2;
  localparam int unsigned NORMAL_HALF   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             changed;
  logic [ACC_W-1:0] counter;
  logic             tick;
  logic [3:0]       idx;
  logic             accent;
  logic             gate;
  logic             wave;

  typedef struct packed {
    logic [3:0] idx;
    logic       accent;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ticks  = 0;
  int   t0;

  metronome_beat_gen #(
    .ACC_W(ACC_W), .BEATS_PER_BAR(BEATS_PER_BAR), .CLICK_LEN(CLICK_LEN),
    .ACCENT_HALF(ACCENT_HALF), .NORMAL_HALF(NORMAL_HALF)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_bpm_counter(counter), .i_bpm_changed(changed),
    .o_beat_tick(tick), .o_beat_idx(idx), .o_accent(accent),
    .o_click_gate(gate), .o_click_wave(wave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every tick must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && tick) begin
      n_ticks++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tick: got idx %0d accent %0d expected no tick at %0t",
                 idx, accent, $time);
      end else begin
        e = q.pop_front();
        check("tick_idx", 32'(idx), 32'(e.idx));
        check("tick_accent", 32'(accent), 32'(e.accent));
        check("tick_gate_wave", 32'({gate, wave}), 32'(2'b11));
      end
    end
  end

  task automatic put(input logic [ACC_W-1:0] v);
    counter = v;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] i, input logic a);
    put(8'd100);
    put(8'd200);
    q.push_back({i, a});
    put(8'd10);
  endtask

  // Called in the tick cycle; checks gate/wave per cycle and the click end.
  task automatic check_click(input int len, input int half);
    for (int k = 0; k < len; k++) begin
      check("click_gate_wave", 32'({gate, wave}), 32'({1'b1, ((k / half) % 2 == 0)}));
      put(counter);
    end
    check("click_end", 32'({gate, wave, accent}), 32'(3'b000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    changed = 1'b0;
    counter = 8'd250;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({tick, idx, accent, gate, wave}), 32'(0));
    reset = 1'b0;

    // First wrap after reset: accented beat 0, 10-cycle gate, half-period 2.
    put(8'd250);
    put(8'd254);
    q.push_back({4'd0, 1'b1});
    put(8'd2);
    check("first_tick_inline", 32'(tick), 32'(1));
    check_click(10, 2);

    // Bar progression 1,2,3,0.
    beat(4'd1, 1'b0); check_click(10, 3);
    beat(4'd2, 1'b0); check_click(10, 3);
    beat(4'd3, 1'b0); check_click(10, 3);
    beat(4'd0, 1'b1); check_click(10, 2);

    // Tempo change resyncs to beat 0, alone and together with a wrap.
    beat(4'd1, 1'b0);
    beat(4'd2, 1'b0);
    changed = 1'b1;
    put(8'd10);
    changed = 1'b0;
    check("changed_holds_idx", 32'({tick, idx}), 32'({1'b0, 4'd2}));
    beat(4'd0, 1'b1);
    beat(4'd1, 1'b0);
    put(8'd100);
    put(8'd200);
    changed = 1'b1;
    q.push_back({4'd0, 1'b1});
    put(8'd10);
    changed = 1'b0;
    repeat (12) put(8'd10);
    check("idle_after_click", 32'({gate, wave}), 32'(0));

    // Retrigger four cycles into a click.
    beat(4'd1, 1'b0);
    check("retrig_k0", 32'({gate, wave}), 32'(2'b11));
    put(8'd100);
    check("retrig_k1", 32'({gate, wave}), 32'(2'b11));
    put(8'd200);
    check("retrig_k2", 32'({gate, wave}), 32'(2'b11));
    put(8'd250);
    check("retrig_k3", 32'({gate, wave}), 32'(2'b10));
    q.push_back({4'd2, 1'b0});
    put(8'd5);
    check_click(10, 3);

    // Disable mid-click, wraps ignored while low, re-enable gives beat 0.
    beat(4'd3, 1'b0);
    put(8'd10);
    put(8'd10);
    enable = 1'b0;
    put(8'd10);
    check("disable_outputs", 32'({tick, idx, gate, wave}), 32'(0));
    put(8'd100);
    put(8'd200);
    put(8'd10);
    check("disabled_wrap_ignored", 32'({tick, idx, gate, wave}), 32'(0));
    enable = 1'b1;
    put(8'd10);
    beat(4'd0, 1'b1);
    check_click(10, 2);

    // Zero increment never ticks.
    t0 = n_ticks;
    repeat (20) put(8'd10);
    check("const_no_tick", 32'(n_ticks - t0), 32'(0));

    // Async reset mid-click.
    beat(4'd1, 1'b0);
    put(8'd10);
    put(8'd10);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'({tick, idx, accent, gate, wave}), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    put(8'd10);
    put(8'd10);
    beat(4'd0, 1'b1);
    check_click(10, 2);

    repeat (3) put(8'd10);
    check("queue_drained", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
